// File: rtl/layer_sched.sv
// Sequences one shared neuron datapath across N_NEURONS neurons of a 3-input layer:
// weight fetch, operand presentation, result wait with watchdog, and result write-out.
module layer_sched #(
    parameter int N_NEURONS = 4,
    parameter int ADDR_W    = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       x1,
    input  logic [15:0]       x2,
    input  logic [15:0]       x3,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              w_rd,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [15:0]       w_data,
    output logic              n_rst,
    output logic [15:0]       nx1,
    output logic [15:0]       nx2,
    output logic [15:0]       nx3,
    output logic [15:0]       nw1,
    output logic [15:0]       nw2,
    output logic [15:0]       nw3,
    output logic              ndone1,
    output logic              ndone2,
    output logic              ndone3,
    input  logic              neuron_done,
    input  logic [15:0]       f,
    output logic              y_wr,
    output logic [3:0]        y_idx,
    output logic [15:0]       y_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FETCH, S_PRESENT, S_WAIT, S_STORE, S_FIN
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  IDX_LAST = 4'(N_NEURONS - 1);
    localparam logic [15:0] QNAN     = 16'h7E00;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [15:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [15:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [15:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            x3_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            x3_q     <= x3_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            w3_q     <= w3_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        err_d    = err_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        x3_d     = x3_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        w3_d     = w3_q;
        result_d = result_q;
        n_rst    = 1'b0;
        w_rd     = 1'b0;
        ndone1   = 1'b0;
        ndone2   = 1'b0;
        ndone3   = 1'b0;
        y_wr     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                n_rst = 1'b1;
                if (start) begin
                    x1_d    = x1;
                    x2_d    = x2;
                    x3_d    = x3;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                n_rst   = 1'b1;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Reads issue on cycles 0..2; RAM data lands one cycle later on 1..3.
                w_rd = (cnt_q < 16'd3);
                case (cnt_q[1:0])
                    2'd1:    w1_d = w_data;
                    2'd2:    w2_d = w_data;
                    2'd3:    w3_d = w_data;
                    default: ;
                endcase
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = S_PRESENT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PRESENT: begin
                ndone1  = 1'b1;
                ndone2  = 1'b1;
                ndone3  = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (neuron_done) begin
                    result_d = f;
                    state_d  = S_STORE;
                end else if (cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    result_d = QNAN;
                    state_d  = S_STORE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STORE: begin
                y_wr = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_CLR;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_addr = w_rd ? (ADDR_W'(idx_q) * ADDR_W'(3) + ADDR_W'(cnt_q[1:0])) : '0;
    assign busy   = busy_q;
    assign err    = err_q;
    assign nx1    = x1_q;
    assign nx2    = x2_q;
    assign nx3    = x3_q;
    assign nw1    = w1_q;
    assign nw2    = w2_q;
    assign nw3    = w3_q;
    assign y_idx  = idx_q;
    assign y_data = result_q;

endmodule
